// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding word memory responder; define DMEM_WAIT_EN to insert WAITCYCLES wait states
module dmem_responder #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 256,
    parameter int WAITCYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic             reqWrite,
    input  logic [WIDTH-1:0] reqAddress,
    input  logic [WIDTH-1:0] reqData,
    output logic             respValid,
    input  logic             respReady,
    output logic [WIDTH-1:0] respData,
    output logic             respError
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_WAIT_EN
    localparam bit WAITEN = 1'b1;
`else
    localparam bit WAITEN = 1'b0;
`endif
    localparam int             EFFWAIT    = WAITEN ? WAITCYCLES : 0;
    localparam logic [WIDTH:0] DEPTHLIMIT = (WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateType;

    stateType         state;
    stateType         nextState;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] respDataReg;
    logic             respErrorReg;
    logic             accept;
    logic             enterResp;
    logic             curWrite;
    logic [WIDTH-1:0] curAddress;
    logic [WIDTH-1:0] curData;
    logic             inRange;
    logic [AW-1:0]    index;
    logic             memWrite;

    assign reqReady = (state == IDLE);
    assign accept   = reqValid & reqReady;

`ifdef DMEM_WAIT_EN
    localparam int CW = (WAITCYCLES > 0) ? $clog2(WAITCYCLES + 1) : 1;

    logic [CW-1:0]    count;
    logic             latWrite;
    logic [WIDTH-1:0] latAddress;
    logic [WIDTH-1:0] latData;

    // capture the request so it can be committed after the wait states
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            latWrite   <= 1'b0;
            latAddress <= '0;
            latData    <= '0;
        end else if (accept) begin
            latWrite   <= reqWrite;
            latAddress <= reqAddress;
            latData    <= reqData;
        end
    end

    // wait-state countdown; reaching zero releases the FSM into RESP
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (accept && (EFFWAIT != 0)) begin
            count <= CW'(EFFWAIT);
        end else if (state == WAIT) begin
            count <= count - CW'(1);
        end
    end

    // a zero-wait acceptance commits straight from the request bus
    assign curWrite   = (state == IDLE) ? reqWrite   : latWrite;
    assign curAddress = (state == IDLE) ? reqAddress : latAddress;
    assign curData    = (state == IDLE) ? reqData    : latData;
`else
    assign curWrite   = reqWrite;
    assign curAddress = reqAddress;
    assign curData    = reqData;
`endif

    assign inRange  = ({1'b0, curAddress} < DEPTHLIMIT);
    assign index    = curAddress[AW-1:0];
    assign memWrite = enterResp & curWrite & inRange;

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // next-state logic; enterResp marks the edge that commits or samples the array
    always_comb begin
        nextState = state;
        enterResp = 1'b0;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    if (EFFWAIT == 0) begin
                        nextState = RESP;
                        enterResp = 1'b1;
                    end
`ifdef DMEM_WAIT_EN
                    else begin
                        nextState = WAIT;
                    end
`endif
                end
            end
`ifdef DMEM_WAIT_EN
            WAIT: begin
                if (count == CW'(1)) begin
                    nextState = RESP;
                    enterResp = 1'b1;
                end
            end
`endif
            RESP: begin
                if (respReady) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // storage array; deliberately not reset so contents survive a reset pulse
    always_ff @(posedge clock) begin
        if (memWrite) begin
            mem[index] <= curData;
        end
    end

    // response payload captured on entry to RESP and held until consumed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            respDataReg  <= '0;
            respErrorReg <= 1'b0;
        end else if (enterResp) begin
            respErrorReg <= ~inRange;
            if (!inRange) begin
                respDataReg <= '0;
            end else if (curWrite) begin
                respDataReg <= curData;
            end else begin
                respDataReg <= mem[index];
            end
        end
    end

    assign respValid = (state == RESP);
    assign respData  = respValid ? respDataReg : '0;
    assign respError = respValid & respErrorReg;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with randomized loads and stores
module tb_dmem_responder;
`ifdef DMEM_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif
    localparam int DEPTH = 256;

    logic        clock;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [15:0] reqAddress;
    logic [15:0] reqData;
    logic        respValid;
    logic        respReady;
    logic [15:0] respData;
    logic        respError;

    dmem_responder #(.WIDTH(16), .DEPTH(DEPTH), .WAITCYCLES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqWrite   (reqWrite),
        .reqAddress (reqAddress),
        .reqData    (reqData),
        .respValid  (respValid),
        .respReady  (respReady),
        .respData   (respData),
        .respError  (respError)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] expData;
        logic        expErr;
        int          firstCycle;
    } entryT;

    entryT       sb[$];
    entryT       e;
    logic [15:0] model [DEPTH];
    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          lastAccept = -1;
    int          readyMode = 1;
    bit          b2bMode = 0;
    bit          expV;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cycle <= cycle + 1;

    always @(posedge clock) begin
        #1;
        case (readyMode)
            0:       respReady = 1'($urandom_range(0, 1));
            1:       respReady = 1'b1;
            default: respReady = 1'b0;
        endcase
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    function automatic void applyStore(input entryT x);
        if (x.wr && x.addr < 16'(DEPTH)) model[x.addr[7:0]] = x.data;
    endfunction

    // monitor: every cycle compare handshake and payload against the head of the scoreboard
    always @(negedge clock) begin
        if (reset) begin
            check("reqReady", 32'(reqReady), 32'(sb.size() == 0));
            expV = (sb.size() > 0) && (cycle >= sb[0].firstCycle);
            check("respValid", 32'(respValid), 32'(expV));
            if (respValid && sb.size() > 0) begin
                check("respData", 32'(respData), 32'(sb[0].expData));
                check("respError", 32'(respError), 32'(sb[0].expErr));
                if (respReady) begin
                    applyStore(sb[0]);
                    sb.delete(0);
                end
            end else if (!respValid) begin
                check("idle respData", 32'(respData), 0);
                check("idle respError", 32'(respError), 0);
            end
            if (reqValid && reqReady) begin
                e.wr   = reqWrite;
                e.addr = reqAddress;
                e.data = reqData;
                if (reqAddress >= 16'(DEPTH)) begin
                    e.expErr  = 1'b1;
                    e.expData = 16'h0;
                end else begin
                    e.expErr  = 1'b0;
                    e.expData = reqWrite ? reqData : model[reqAddress[7:0]];
                end
                e.firstCycle = cycle + 1 + W;
                if (b2bMode && lastAccept >= 0) check("accept spacing", 32'(cycle - lastAccept), 32'(W + 2));
                lastAccept = cycle;
                sb.push_back(e);
            end
        end
    end

    task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d, input bit hold);
        int n;
        n = 0;
        reqValid   = 1'b1;
        reqWrite   = wr;
        reqAddress = a;
        reqData    = d;
        @(negedge clock);
        while (!reqReady && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!reqReady) failNow("accept timeout");
        @(posedge clock);
        #1;
        if (!hold) reqValid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() > 0) begin
            failNow("response timeout");
            sb.delete();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        #1;
        check("reset respValid", 32'(respValid), 0);
        check("reset reqReady", 32'(reqReady), 1);
        check("reset respData", 32'(respData), 0);
        check("reset respError", 32'(respError), 0);
        if (sb.size() > 0) begin
            if (cycle >= sb[0].firstCycle) applyStore(sb[0]);
            sb.delete();
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        logic [15:0] a;
        reset      = 1'b1;
        reqValid   = 1'b0;
        reqWrite   = 1'b0;
        reqAddress = 16'h0;
        reqData    = 16'h0;
        respReady  = 1'b1;
        #1;
        pulseReset();

        for (int i = 0; i < DEPTH; i++) issue(1'b1, 16'(i), 16'($urandom), 1'b0);
        waitIdle();

        issue(1'b1, 16'd5, 16'h1234, 1'b0);
        issue(1'b0, 16'd5, 16'h0, 1'b0);
        waitIdle();

        issue(1'b1, 16'd300, 16'($urandom), 1'b0);
        issue(1'b0, 16'd44, 16'h0, 1'b0);
        waitIdle();

        readyMode = 2;
        a = 16'($urandom_range(0, DEPTH - 1));
        issue(1'b0, a, 16'h0, 1'b0);
        n = 0;
        while (!respValid && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!respValid) failNow("stall response");
        for (int k = 0; k < 4; k++) begin
            check("stall respValid", 32'(respValid), 1);
            check("stall respData", 32'(respData), 32'(model[a[7:0]]));
            check("stall reqReady", 32'(reqReady), 0);
            @(posedge clock);
            #1;
            reqValid   = (k == 0);
            reqWrite   = 1'b1;
            reqAddress = 16'd9;
            reqData    = 16'hDEAD;
            @(negedge clock);
        end
        readyMode = 1;
        waitIdle();

        issue(1'b1, 16'd7, 16'hBEEF, 1'b0);
        #1;
        pulseReset();
        issue(1'b0, 16'd7, 16'h0, 1'b0);
        waitIdle();

        lastAccept = -1;
        b2bMode = 1;
        for (int k = 0; k < 10; k++)
            issue(1'($urandom_range(0, 1)), 16'($urandom_range(0, DEPTH - 1)), 16'($urandom), 1'b1);
        reqValid = 1'b0;
        waitIdle();
        b2bMode = 0;

        readyMode = 0;
        for (int k = 0; k < 300; k++)
            issue(1'($urandom_range(0, 1)), 16'($urandom_range(0, 299)), 16'($urandom), 1'b0);
        readyMode = 1;
        waitIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
